idex_alu_issue: RTL and testbench
=================================

// Module: idex_alu_issue
// PURPOSE
//  ID/EX pipeline stage that issues work to the ALU: decodes a MIPS instruction into ALUFun/Sign,
//  selects and registers operands A/B, and carries the writeback/memory controls one stage forward.
//  It is the encoder side of the ALUFun interface; the ALU decodes it. Sits between decode and EX.
// PARAMETERS
//  DATA_W     32  datapath width; only 32 is supported.
//  TRAP_ILL   1   1: an unknown opcode/funct raises illegal_out; 0: it issues silently as a NOP.
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  instr_in    in   32      instruction from IF/ID
//  valid_in    in   1       instr_in is a real instruction, not a bubble
//  rs_data     in   32      forwarded rs value
//  rt_data     in   32      forwarded rt value
//  stall       in   1       hold all stage registers
//  flush       in   1       replace the stage contents with a bubble
//  alu_a       out  32      ALU operand A (registered)
//  alu_b       out  32      ALU operand B (registered)
//  alu_fun     out  6       ALUFun to the ALU (registered)
//  alu_sign    out  1       signed compare/overflow select (registered)
//  wb_addr     out  5       destination register; 0 means no write
//  reg_write   out  1       write back ALU result or load data
//  mem_read    out  1       lw
//  mem_write   out  1       sw; store data on st_data
//  st_data     out  32      rt_data captured for sw
//  is_branch   out  1       beq/bne/blez/bgtz/bltz; ALU result bit0 = taken
//  valid_out   out  1       stage holds a real instruction
//  illegal_out out  1       unsupported encoding (1-cycle, with valid_out=0)
// BEHAVIOUR
//  Reset: every output is 0; alu_fun=6'b000000 (ADD); valid_out=0.
//  Latency: 1 cycle, from instr_in sampled at an edge to the registered outputs after that edge.
//  Priority at each edge: flush > stall > load.
//   - flush: clears valid_out, reg_write, mem_*, is_branch, illegal_out. Data regs are don't-care.
//   - stall (no flush): all outputs hold their values, including illegal_out.
//   - load with valid_in=0: same result as a flush (bubble).
//  ALUFun map. [5:4]: 00 adder, 01 logic, 10 shift, 11 compare.
//   ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001,
//   SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101,
//   LEZ 111101, LTZ 111011, GTZ 111111.
//  Operand rules:
//   - R-type: A=rs, B=rt, wb=rd.
//   - sll/srl/sra: A={27'b0,shamt}, B=rt.
//   - sllv/srlv/srav: A=rs, B=rt.
//   - addi/addiu/slti/sltiu/lw/sw: B=sign-extended imm.
//   - andi/ori/xori: B=zero-extended imm.
//   - lui: A=0, B={imm,16'b0}, ADD.
//   - I-type: wb=rt.
//  Sign:
//   - 0 for addu/subu/addiu/sltu/sltiu; 1 for every other instruction.
//   - slt/sltu map to LT.
//   - lw/sw use ADD for the address calculation.
//  Branches: beq/bne use EQ/NEQ with B=rt; blez/bgtz/bltz use LEZ/GTZ/LTZ with B=0.
//   reg_write=0; is_branch=1.
//  Destination register 0: reg_write is forced to 0 (no write to $0).
//  Illegal encoding with TRAP_ILL=1: valid_out=0, illegal_out=1 for exactly that load cycle.
//  Reset asserted mid-stall clears the stage immediately (asynchronous).
// STRUCTURE
//  Shared package: ALUFun localparams (names above), opcode/funct constants, and the field slices
//  for rs/rt/rd/shamt/imm.
//  One sub-module: idex_alu_decode, purely combinational: instr -> {alu_fun, sign, A/B selects,
//  ext mode, wb select, control bits, illegal}.
//  Top level: operand muxes plus the flush/stall pipeline register.
// TESTING
//  1. Reset low: all outputs 0. Release reset, then load add $3,$1,$2 with rs=5, rt=7
//     -> next cycle alu_fun=000000, A=5, B=7, wb=3, reg_write=1, valid_out=1.
//  2. addiu $4,$0,-1 -> B=32'hFFFFFFFF, sign=0.
//     ori $4,$0,0xFFFF -> B=32'h0000FFFF, alu_fun=011110.
//  3. sra $2,$5,4 with rt=32'h80000000 -> A=4, B=32'h80000000, alu_fun=100011.
//     lui $1,0x1234 -> B=32'h12340000.
//  4. stall=1 for 3 cycles while instr_in changes -> outputs frozen.
//     Then assert stall and flush together -> bubble (valid_out=0, reg_write=0).
//  5. beq with rs=rt=9 -> alu_fun=110011, is_branch=1, reg_write=0.
//     bgtz -> alu_fun=111111, B=0.
//     add $0,... -> reg_write=0.
//  6. Opcode 6'h3F with TRAP_ILL=1 -> illegal_out=1, valid_out=0 for one cycle.
//     Assert reset mid-stall -> all outputs go to 0 immediately.

Source files
------------

// File: rtl/idex_alu_issue_pkg.sv
// Shared definitions for the ID/EX ALU issue stage: ALUFun codes, MIPS opcode/funct
// values, operand-select enums and instruction field slices.
package idex_alu_issue_pkg;

  // ALUFun encoding; [5:4] picks the ALU unit (adder, logic, shift, compare)
  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {A_RS, A_SHAMT, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_RT, B_IMM, B_ZERO} b_sel_e;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_e;
  typedef enum logic [1:0] {WB_NONE, WB_RD, WB_RT} wb_sel_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] ins); return ins[31:26]; endfunction
  function automatic logic [4:0] f_rs(input logic [31:0] ins);     return ins[25:21]; endfunction
  function automatic logic [4:0] f_rt(input logic [31:0] ins);     return ins[20:16]; endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] ins);     return ins[15:11]; endfunction
  function automatic logic [4:0] f_shamt(input logic [31:0] ins);  return ins[10:6];  endfunction
  function automatic logic [15:0] f_imm(input logic [31:0] ins);   return ins[15:0];  endfunction
  function automatic logic [5:0] f_funct(input logic [31:0] ins);  return ins[5:0];   endfunction

endpackage

// File: rtl/idex_alu_issue_decode.sv
// Combinational MIPS decoder: opcode/funct -> ALUFun, sign, operand selects and
// control bits. Illegal encodings come out with every control bit cleared.
module idex_alu_issue_decode
  import idex_alu_issue_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] rt_i,
  input  logic [5:0] funct_i,
  output logic [5:0] alu_fun_o,
  output logic       sign_o,
  output logic [1:0] a_sel_o,
  output logic [1:0] b_sel_o,
  output logic [1:0] ext_o,
  output logic [1:0] wb_sel_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       is_branch_o,
  output logic       illegal_o
);

  always_comb begin
    alu_fun_o   = ALU_ADD;
    sign_o      = 1'b1;
    a_sel_o     = A_RS;
    b_sel_o     = B_RT;
    ext_o       = EXT_SIGN;
    wb_sel_o    = WB_NONE;
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    is_branch_o = 1'b0;
    illegal_o   = 1'b0;

    case (opcode_i)
      OP_RTYPE: begin
        wb_sel_o    = WB_RD;
        reg_write_o = 1'b1;
        case (funct_i)
          FN_SLL:  begin alu_fun_o = ALU_SLL; a_sel_o = A_SHAMT; end
          FN_SRL:  begin alu_fun_o = ALU_SRL; a_sel_o = A_SHAMT; end
          FN_SRA:  begin alu_fun_o = ALU_SRA; a_sel_o = A_SHAMT; end
          FN_SLLV: alu_fun_o = ALU_SLL;
          FN_SRLV: alu_fun_o = ALU_SRL;
          FN_SRAV: alu_fun_o = ALU_SRA;
          FN_ADD:  alu_fun_o = ALU_ADD;
          FN_ADDU: sign_o = 1'b0;
          FN_SUB:  alu_fun_o = ALU_SUB;
          FN_SUBU: begin alu_fun_o = ALU_SUB; sign_o = 1'b0; end
          FN_AND:  alu_fun_o = ALU_AND;
          FN_OR:   alu_fun_o = ALU_OR;
          FN_XOR:  alu_fun_o = ALU_XOR;
          FN_NOR:  alu_fun_o = ALU_NOR;
          FN_SLT:  alu_fun_o = ALU_LT;
          FN_SLTU: begin alu_fun_o = ALU_LT; sign_o = 1'b0; end
          default: begin
            illegal_o   = 1'b1;
            wb_sel_o    = WB_NONE;
            reg_write_o = 1'b0;
          end
        endcase
      end
      // Only bltz (rt=0) is supported in the REGIMM group
      OP_REGIMM: begin
        if (rt_i == 5'd0) begin
          alu_fun_o   = ALU_LTZ;
          b_sel_o     = B_ZERO;
          is_branch_o = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_BEQ:  begin alu_fun_o = ALU_EQ;  is_branch_o = 1'b1; end
      OP_BNE:  begin alu_fun_o = ALU_NEQ; is_branch_o = 1'b1; end
      OP_BLEZ: begin alu_fun_o = ALU_LEZ; b_sel_o = B_ZERO; is_branch_o = 1'b1; end
      OP_BGTZ: begin alu_fun_o = ALU_GTZ; b_sel_o = B_ZERO; is_branch_o = 1'b1; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        b_sel_o     = B_IMM;
        wb_sel_o    = WB_RT;
        reg_write_o = 1'b1;
        if (opcode_i == OP_SLTI || opcode_i == OP_SLTIU) alu_fun_o = ALU_LT;
        if (opcode_i == OP_ADDIU || opcode_i == OP_SLTIU) sign_o = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        b_sel_o     = B_IMM;
        ext_o       = EXT_ZERO;
        wb_sel_o    = WB_RT;
        reg_write_o = 1'b1;
        alu_fun_o   = (opcode_i == OP_ANDI) ? ALU_AND :
                      (opcode_i == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        a_sel_o     = A_ZERO;
        b_sel_o     = B_IMM;
        ext_o       = EXT_LUI;
        wb_sel_o    = WB_RT;
        reg_write_o = 1'b1;
      end
      OP_LW: begin
        b_sel_o     = B_IMM;
        wb_sel_o    = WB_RT;
        reg_write_o = 1'b1;
        mem_read_o  = 1'b1;
      end
      OP_SW: begin
        b_sel_o     = B_IMM;
        mem_write_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/idex_alu_issue.sv
// ID/EX issue stage: decodes the instruction, muxes ALU operands and registers them
// together with the writeback/memory controls behind a flush > stall > load priority.
module idex_alu_issue
  import idex_alu_issue_pkg::*;
#(
  parameter int DATA_W   = 32,   // only 32 is supported
  parameter bit TRAP_ILL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_fun,
  output logic              alu_sign,
  output logic [4:0]        wb_addr,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] st_data,
  output logic              is_branch,
  output logic              valid_out,
  output logic              illegal_out
);

  logic [5:0] dec_fun;
  logic       dec_sign, dec_rw, dec_mr, dec_mw, dec_br, dec_ill;
  logic [1:0] dec_a_sel, dec_b_sel, dec_ext, dec_wb_sel;

  idex_alu_issue_decode u_decode (
    .opcode_i    (f_opcode(instr_in)),
    .rt_i        (f_rt(instr_in)),
    .funct_i     (f_funct(instr_in)),
    .alu_fun_o   (dec_fun),
    .sign_o      (dec_sign),
    .a_sel_o     (dec_a_sel),
    .b_sel_o     (dec_b_sel),
    .ext_o       (dec_ext),
    .wb_sel_o    (dec_wb_sel),
    .reg_write_o (dec_rw),
    .mem_read_o  (dec_mr),
    .mem_write_o (dec_mw),
    .is_branch_o (dec_br),
    .illegal_o   (dec_ill)
  );

  logic [DATA_W-1:0] imm_ext, op_a, op_b;
  logic [4:0]        wb_sel_addr;

  always_comb begin
    case (dec_ext)
      EXT_ZERO: imm_ext = {{(DATA_W-16){1'b0}}, f_imm(instr_in)};
      EXT_LUI:  imm_ext = {f_imm(instr_in), {(DATA_W-16){1'b0}}};
      default:  imm_ext = {{(DATA_W-16){instr_in[15]}}, f_imm(instr_in)};
    endcase
    case (dec_a_sel)
      A_SHAMT: op_a = {{(DATA_W-5){1'b0}}, f_shamt(instr_in)};
      A_ZERO:  op_a = '0;
      default: op_a = rs_data;
    endcase
    case (dec_b_sel)
      B_IMM:   op_b = imm_ext;
      B_ZERO:  op_b = '0;
      default: op_b = rt_data;
    endcase
    case (dec_wb_sel)
      WB_RD:   wb_sel_addr = f_rd(instr_in);
      WB_RT:   wb_sel_addr = f_rt(instr_in);
      default: wb_sel_addr = 5'd0;
    endcase
  end

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, st_q, st_d;
  logic [5:0]        fun_q, fun_d;
  logic [4:0]        wb_q, wb_d;
  logic              sign_q, sign_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
  logic              br_q, br_d, valid_q, valid_d, ill_q, ill_d;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    st_d    = st_q;
    fun_d   = fun_q;
    wb_d    = wb_q;
    sign_d  = sign_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    br_d    = br_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    if (flush) begin
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = 1'b0;
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      a_d     = op_a;
      b_d     = op_b;
      st_d    = rt_data;
      fun_d   = dec_fun;
      wb_d    = wb_sel_addr;
      sign_d  = dec_sign;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = 1'b0;
      valid_d = 1'b0;
      ill_d   = 1'b0;
      // Without trapping, an illegal encoding issues as a control-free NOP
      if (valid_in) begin
        if (dec_ill && TRAP_ILL) begin
          ill_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          rw_d    = dec_rw && (wb_sel_addr != 5'd0);
          mr_d    = dec_mr;
          mw_d    = dec_mw;
          br_d    = dec_br;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      st_q    <= '0;
      fun_q   <= ALU_ADD;
      wb_q    <= 5'd0;
      sign_q  <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      st_q    <= st_d;
      fun_q   <= fun_d;
      wb_q    <= wb_d;
      sign_q  <= sign_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign st_data     = st_q;
  assign alu_fun     = fun_q;
  assign wb_addr     = wb_q;
  assign alu_sign    = sign_q;
  assign reg_write   = rw_q;
  assign mem_read    = mr_q;
  assign mem_write   = mw_q;
  assign is_branch   = br_q;
  assign valid_out   = valid_q;
  assign illegal_out = ill_q;

endmodule

// File: tb/tb_idex_alu_issue.sv
// Self-checking bench for idex_alu_issue: directed cases followed by random traffic
// compared against an instruction-level reference model.
module tb_idex_alu_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] alu_a, alu_b, st_data;
  logic [5:0]  alu_fun;
  logic [4:0]  wb_addr;
  logic        alu_sign, reg_write, mem_read, mem_write, is_branch, valid_out, illegal_out;

  idex_alu_issue #(.DATA_W(32), .TRAP_ILL(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .valid_in(valid_in),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .wb_addr(wb_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .st_data(st_data), .is_branch(is_branch),
    .valid_out(valid_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        legal, valid, ill, rw, mr, mw, br, sign;
    logic [5:0]  fun;
    logic [4:0]  wb;
    logic [31:0] a, b, st;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t m = '0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction-level meaning of each supported MIPS instruction
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0]  opc, fn;
    logic [4:0]  rtf, rd, sh;
    logic [31:0] simm, zimm;
    opc = ins[31:26]; fn = ins[5:0]; rtf = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    e = '0; e.legal = 1'b1; e.sign = 1'b1; e.a = rs; e.b = rt; e.st = rt;
    case (opc)
      6'h00: begin
        e.wb = rd; e.rw = 1'b1;
        case (fn)
          6'h00: begin e.fun = 6'b100000; e.a = {27'd0, sh}; end
          6'h02: begin e.fun = 6'b100001; e.a = {27'd0, sh}; end
          6'h03: begin e.fun = 6'b100011; e.a = {27'd0, sh}; end
          6'h04: e.fun = 6'b100000;
          6'h06: e.fun = 6'b100001;
          6'h07: e.fun = 6'b100011;
          6'h20: e.fun = 6'b000000;
          6'h21: begin e.fun = 6'b000000; e.sign = 1'b0; end
          6'h22: e.fun = 6'b000001;
          6'h23: begin e.fun = 6'b000001; e.sign = 1'b0; end
          6'h24: e.fun = 6'b011000;
          6'h25: e.fun = 6'b011110;
          6'h26: e.fun = 6'b010110;
          6'h27: e.fun = 6'b010001;
          6'h2A: e.fun = 6'b110101;
          6'h2B: begin e.fun = 6'b110101; e.sign = 1'b0; end
          default: e.legal = 1'b0;
        endcase
      end
      6'h01: if (rtf == 5'd0) begin e.fun = 6'b111011; e.b = 0; e.br = 1'b1; end
             else e.legal = 1'b0;
      6'h04: begin e.fun = 6'b110011; e.br = 1'b1; end
      6'h05: begin e.fun = 6'b110001; e.br = 1'b1; end
      6'h06: begin e.fun = 6'b111101; e.b = 0; e.br = 1'b1; end
      6'h07: begin e.fun = 6'b111111; e.b = 0; e.br = 1'b1; end
      6'h08: begin e.b = simm; e.wb = rtf; e.rw = 1'b1; end
      6'h09: begin e.b = simm; e.wb = rtf; e.rw = 1'b1; e.sign = 1'b0; end
      6'h0A: begin e.fun = 6'b110101; e.b = simm; e.wb = rtf; e.rw = 1'b1; end
      6'h0B: begin e.fun = 6'b110101; e.b = simm; e.wb = rtf; e.rw = 1'b1; e.sign = 1'b0; end
      6'h0C: begin e.fun = 6'b011000; e.b = zimm; e.wb = rtf; e.rw = 1'b1; end
      6'h0D: begin e.fun = 6'b011110; e.b = zimm; e.wb = rtf; e.rw = 1'b1; end
      6'h0E: begin e.fun = 6'b010110; e.b = zimm; e.wb = rtf; e.rw = 1'b1; end
      6'h0F: begin e.a = 0; e.b = {ins[15:0], 16'h0000}; e.wb = rtf; e.rw = 1'b1; end
      6'h23: begin e.b = simm; e.wb = rtf; e.rw = 1'b1; e.mr = 1'b1; end
      6'h2B: begin e.b = simm; e.mw = 1'b1; end
      default: e.legal = 1'b0;
    endcase
    if (e.wb == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic compare_all(input string pfx);
    chk_eq({pfx, ".valid"},   valid_out,   m.valid);
    chk_eq({pfx, ".illegal"}, illegal_out, m.ill);
    chk_eq({pfx, ".reg_wr"},  reg_write,   m.rw);
    chk_eq({pfx, ".mem_rd"},  mem_read,    m.mr);
    chk_eq({pfx, ".mem_wr"},  mem_write,   m.mw);
    chk_eq({pfx, ".branch"},  is_branch,   m.br);
    if (m.valid) begin
      chk_eq({pfx, ".fun"},  alu_fun,  m.fun);
      chk_eq({pfx, ".sign"}, alu_sign, m.sign);
      chk_eq({pfx, ".a"},    alu_a,    m.a);
      chk_eq({pfx, ".b"},    alu_b,    m.b);
      chk_eq({pfx, ".wb"},   wb_addr,  m.wb);
      if (m.mw) chk_eq({pfx, ".st"}, st_data, m.st);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk_eq({pfx, ".a"}, alu_a, 0);          chk_eq({pfx, ".b"}, alu_b, 0);
    chk_eq({pfx, ".fun"}, alu_fun, 0);      chk_eq({pfx, ".sign"}, alu_sign, 0);
    chk_eq({pfx, ".wb"}, wb_addr, 0);       chk_eq({pfx, ".reg_wr"}, reg_write, 0);
    chk_eq({pfx, ".mem_rd"}, mem_read, 0);  chk_eq({pfx, ".mem_wr"}, mem_write, 0);
    chk_eq({pfx, ".st"}, st_data, 0);       chk_eq({pfx, ".branch"}, is_branch, 0);
    chk_eq({pfx, ".valid"}, valid_out, 0);  chk_eq({pfx, ".illegal"}, illegal_out, 0);
  endtask

  // One clock: drive at negedge, advance the model at the edge, compare at next negedge
  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic st, input logic fl, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    instr_in = ins; valid_in = v; stall = st; flush = fl; rs_data = rs; rt_data = rt;
    @(posedge clk);
    if (fl || (!st && !v)) begin
      m.valid = 0; m.ill = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0;
    end else if (!st) begin
      e = ref_decode(ins, rs, rt);
      if (e.legal) begin
        m = e; m.valid = 1'b1; m.ill = 1'b0;
      end else begin
        m.valid = 0; m.ill = 1; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0;
      end
    end
    @(negedge clk);
    $display("[TB] %s instr=%h v=%0d stall=%0d flush=%0d -> valid=%0d ill=%0d fun=%b a=%h b=%h wb=%0d",
             tag, ins, v, st, fl, valid_out, illegal_out, alu_fun, alu_a, alu_b, wb_addr);
    compare_all(tag);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [5:0] rfn_list [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] op_list [16]  = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
                                6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h01};

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) ins[31:26] = 6'h00;
    if (k < 3) ins[5:0] = rfn_list[$urandom_range(0, 15)];
    else if (k < 9 && k > 3) begin
      ins[31:26] = op_list[$urandom_range(0, 15)];
      if (ins[31:26] == 6'h01 && $urandom_range(0, 1) == 0) ins[20:16] = 5'd0;
    end
    return ins;
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    step("add", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1, 0, 0, 32'd5, 32'd7);
    chk_eq("add.fun", alu_fun, 6'b000000); chk_eq("add.a", alu_a, 5); chk_eq("add.b", alu_b, 7);
    chk_eq("add.wb", wb_addr, 3); chk_eq("add.rw", reg_write, 1); chk_eq("add.v", valid_out, 1);

    step("addiu", itype(6'h09, 5'd0, 5'd4, 16'hFFFF), 1, 0, 0, 32'd0, 32'd0);
    chk_eq("addiu.b", alu_b, 32'hFFFF_FFFF); chk_eq("addiu.sign", alu_sign, 0);
    step("ori", itype(6'h0D, 5'd0, 5'd4, 16'hFFFF), 1, 0, 0, 32'd0, 32'd0);
    chk_eq("ori.b", alu_b, 32'h0000_FFFF); chk_eq("ori.fun", alu_fun, 6'b011110);

    step("sra", rtype(5'd0, 5'd5, 5'd2, 5'd4, 6'h03), 1, 0, 0, 32'h1234, 32'h8000_0000);
    chk_eq("sra.a", alu_a, 4); chk_eq("sra.b", alu_b, 32'h8000_0000); chk_eq("sra.fun", alu_fun, 6'b100011);
    step("lui", itype(6'h0F, 5'd0, 5'd1, 16'h1234), 1, 0, 0, 32'hDEAD, 32'hBEEF);
    chk_eq("lui.b", alu_b, 32'h1234_0000); chk_eq("lui.a", alu_a, 0);

    for (int i = 0; i < 3; i++) begin
      step("stall", rand_instr(), 1, 1, 0, $urandom, $urandom);
      chk_eq("stall.b", alu_b, 32'h1234_0000);
    end
    step("stall_flush", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1, 1, 1, 1, 2);
    chk_eq("sf.valid", valid_out, 0); chk_eq("sf.rw", reg_write, 0);

    step("beq", itype(6'h04, 5'd1, 5'd2, 16'h0010), 1, 0, 0, 9, 9);
    chk_eq("beq.fun", alu_fun, 6'b110011); chk_eq("beq.br", is_branch, 1); chk_eq("beq.rw", reg_write, 0);
    step("bgtz", itype(6'h07, 5'd1, 5'd0, 16'h0010), 1, 0, 0, 9, 9);
    chk_eq("bgtz.fun", alu_fun, 6'b111111); chk_eq("bgtz.b", alu_b, 0);
    step("add0", rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 1, 0, 0, 3, 4);
    chk_eq("add0.rw", reg_write, 0);
    step("sw", itype(6'h2B, 5'd1, 5'd2, 16'hFFF0), 1, 0, 0, 32'h100, 32'hCAFE);
    chk_eq("sw.st", st_data, 32'hCAFE);

    step("ill", 32'hFC00_0000, 1, 0, 0, 1, 2);
    chk_eq("ill.ill", illegal_out, 1); chk_eq("ill.valid", valid_out, 0);
    step("after_ill", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 1, 0, 0, 1, 2);
    chk_eq("after_ill.ill", illegal_out, 0);

    // Asynchronous reset while stalled
    step("pre_rst", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1, 0, 0, 11, 22);
    step("rst_stall", rand_instr(), 1, 1, 0, $urandom, $urandom);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    $display("[TB] async reset mid-stall -> valid=%0d a=%h", valid_out, alu_a);
    m = '0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 500; i++) begin
      step("rand", rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 11) == 0), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
